load_store_unit: RTL and testbench

- Memory-stage responder to the control decoder's memory signals (load_mem, mem_write, mem_width, mem_sign_extend).
- Converts each core byte/half/word access into one word-aligned request/acknowledge transaction on the data-memory bus.
- Stalls the pipeline until the transaction completes.
- Returns load data aligned to bit 0 and sign- or zero-extended.

---
 rtl/load_store_unit_pkg.sv | 27 ++
 rtl/load_store_unit_mem_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 120 ++++++++++++
 tb/tb_load_store_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the memory stage: access widths (common with the control
// decoder) and the load/store FSM states.
package load_store_unit_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // The reserved width is reported as misaligned so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        logic r;
        case (width)
            MEM_BYTE: r = 1'b0;
            MEM_HALF: r = off[0];
            MEM_WORD: r = |off;
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_mem_lane_align.sv
// Combinational byte-lane steering: store enables/replication from the live core
// request, load extraction/extension from the registered request.
module mem_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_st_width,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_bus_wdata,
    input  logic [1:0]  i_ld_width,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_sext,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be        = 4'b1111;
        o_bus_wdata = i_wdata;
        case (i_st_width)
            MEM_BYTE: begin
                o_be        = 4'b0001 << i_st_off;
                o_bus_wdata = {4{i_wdata[7:0]}};
            end
            MEM_HALF: begin
                o_be        = 4'b0011 << {i_st_off[1], 1'b0};
                o_bus_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = i_bus_rdata[{i_ld_off, 3'b000} +: 8];
    assign w_half = i_ld_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

    always_comb begin
        o_ld_data = i_bus_rdata;
        case (i_ld_width)
            MEM_BYTE: o_ld_data = {{24{i_ld_sext & w_byte[7]}}, w_byte};
            MEM_HALF: o_ld_data = {{16{i_ld_sext & w_half[15]}}, w_half};
            default:  ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns one core access into a single word-aligned
// req/ack bus transaction, stalling the pipeline until it completes.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_mem,
    input  logic              mem_write,
    input  logic [1:0]        mem_width,
    input  logic              mem_sign_extend,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              w_access;
    logic              w_misalign_raw;
    logic              w_go;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_bus_wdata;
    logic [DATA_W-1:0] w_ld_data;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_width;
    logic [1:0]        r_off;
    logic              r_sext;

    assign w_access       = load_mem | mem_write;
    assign w_misalign_raw = is_misaligned(mem_width, addr[1:0]);
    assign w_go           = w_access & ~w_misalign_raw;

    mem_lane_align u_align (
        .i_st_width  (mem_width),
        .i_st_off    (addr[1:0]),
        .i_wdata     (wdata),
        .o_be        (w_be),
        .o_bus_wdata (w_bus_wdata),
        .i_ld_width  (r_width),
        .i_ld_off    (r_off),
        .i_ld_sext   (r_sext),
        .i_bus_rdata (bus_rdata),
        .o_ld_data   (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // DONE always falls back to IDLE so a still-held access is not reissued here.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_go) w_next = ST_BUSY;
            ST_BUSY: if (bus_ack) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall      = w_go & (r_state != ST_DONE);
        misaligned = w_access & w_misalign_raw;
        rdata      = misaligned ? '0 : r_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_width <= '0;
            r_off   <= '0;
            r_sext  <= 1'b0;
        end else if (r_state == ST_IDLE && w_go) begin
            r_req   <= 1'b1;
            r_we    <= mem_write;
            r_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_bus_wdata;
            r_width <= mem_width;
            r_off   <= addr[1:0];
            r_sext  <= mem_sign_extend;
        end else if (r_state == ST_BUSY && bus_ack) begin
            // A store (including load+store together) returns zero.
            r_req   <= 1'b0;
            r_rdata <= r_we ? '0 : w_ld_data;
        end
    end

    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a wait-state memory responder and
// an expected-transaction scoreboard.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        load_mem;
    logic        mem_write;
    logic [1:0]  mem_width;
    logic        mem_sign_extend;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .load_mem(load_mem), .mem_write(mem_write),
        .mem_width(mem_width), .mem_sign_extend(mem_sign_extend), .addr(addr),
        .wdata(wdata), .rdata(rdata), .stall(stall), .misaligned(misaligned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ld;
        bit          st;
        logic [1:0]  w;
        bit          sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rw;
        int          waits;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        int          e_stall;
    } stim_t;

    typedef struct {
        bit          we;
        bit          chk_wd;
        bit          chk_rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          stall;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int failures;
    int txn_cnt;
    logic prev_req;

    int          ob_cnt;
    bit          ob_to;
    bit          ob_unstable;
    logic        ob_we;
    logic [31:0] ob_addr;
    logic [3:0]  ob_be;
    logic [31:0] ob_wdata;
    logic [31:0] ob_rdata;

    initial prev_req = 1'b0;
    always @(negedge clk) begin
        if (bus_req && !prev_req) txn_cnt++;
        prev_req = bus_req;
    end

    // Drive one access, play a memory with 'waits' wait cycles, record what the DUT did.
    task automatic run_access(input bit ld, input bit st, input logic [1:0] w, input bit sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rw, input int waits, input bit hold_done);
        int left;
        bit got;
        @(negedge clk);
        load_mem = ld; mem_write = st; mem_width = w; mem_sign_extend = sx;
        addr = a; wdata = wd; bus_ack = 1'b0;
        #1;
        ob_cnt = 0; ob_to = 0; ob_unstable = 0; got = 0; left = waits;
        while (stall) begin
            ob_cnt++;
            if (ob_cnt > 60) begin ob_to = 1; break; end
            @(negedge clk);
            if (bus_req) begin
                if (!got) begin
                    ob_we = bus_we; ob_addr = bus_addr; ob_be = bus_be; ob_wdata = bus_wdata;
                    got = 1;
                end else if (ob_we !== bus_we || ob_addr !== bus_addr ||
                             ob_be !== bus_be || ob_wdata !== bus_wdata) begin
                    ob_unstable = 1;
                end
                if (left == 0) begin
                    bus_ack = 1'b1; bus_rdata = rw;
                end else begin
                    left--; bus_ack = 1'b0; bus_rdata = 32'h0BAD_0BAD;
                end
            end else begin
                bus_ack = 1'b0;
            end
            #1;
        end
        bus_ack = 1'b0;
        ob_rdata = rdata;
        if (hold_done) @(negedge clk);
        load_mem = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_mem = 0; mem_write = 0; mem_width = 2'b00; mem_sign_extend = 0;
        addr = '0; wdata = '0; bus_ack = 0; bus_rdata = '0;
        #12;
        checks++;
        if (bus_req !== 1'b0 || bus_we !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got req=%b we=%b stall=%b want 0 0 0", bus_req, bus_we, stall);
        end
        checks++;
        if (bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got addr=%h be=%h wd=%h rd=%h want zeros",
                     bus_addr, bus_be, bus_wdata, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lanes();
        stim_t tbl[9];
        exp_t  e;
        tbl = '{
            '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h1111_1111, 0,
              32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0, 2},
            '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_0000, 3,
              32'h0000_0200, 4'b1000, 32'h0, 32'hFFFF_FF80, 5},
            '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h9ABC_1234, 1,
              32'h0000_0000, 4'b1100, 32'h0, 32'h0000_9ABC, 3},
            '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_5678, 32'h0, 0,
              32'h0000_0000, 4'b1100, 32'h5678_5678, 32'h0, 2},
            '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1001, 32'h1234_56AB, 32'h0, 2,
              32'h0000_1000, 4'b0010, 32'hABAB_ABAB, 32'h0, 4},
            '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0, 32'h0000_CD00, 0,
              32'h0000_1000, 4'b0010, 32'h0, 32'h0000_00CD, 2},
            '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0040, 32'h0, 32'h7FFF_8001, 0,
              32'h0000_0040, 4'b0011, 32'h0, 32'hFFFF_8001, 2},
            '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1,
              32'h0000_0008, 4'b1111, 32'h0, 32'hCAFE_F00D, 3},
            '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0002, 32'h0, 32'h007F_0000, 0,
              32'h0000_0000, 4'b0100, 32'h0, 32'h0000_007F, 2}
        };
        foreach (tbl[i]) begin
            exp_q.push_back('{tbl[i].st, tbl[i].st, tbl[i].ld, tbl[i].e_addr, tbl[i].e_be,
                              tbl[i].e_wd, tbl[i].e_rd, tbl[i].e_stall});
            run_access(tbl[i].ld, tbl[i].st, tbl[i].w, tbl[i].sx, tbl[i].a, tbl[i].wd,
                       tbl[i].rw, tbl[i].waits, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (ob_to) begin
                failures++;
                $display("FAIL lanes[%0d] timeout got stall stuck want completion", i);
                continue;
            end
            checks++;
            if (ob_cnt != e.stall) begin
                failures++; $display("FAIL lanes[%0d] stall_cycles got=%0d want=%0d", i, ob_cnt, e.stall);
            end
            checks++;
            if (ob_we !== e.we) begin
                failures++; $display("FAIL lanes[%0d] bus_we got=%b want=%b", i, ob_we, e.we);
            end
            checks++;
            if (ob_addr !== e.addr) begin
                failures++; $display("FAIL lanes[%0d] bus_addr got=%h want=%h", i, ob_addr, e.addr);
            end
            checks++;
            if (ob_be !== e.be) begin
                failures++; $display("FAIL lanes[%0d] bus_be got=%b want=%b", i, ob_be, e.be);
            end
            checks++;
            if (ob_unstable) begin
                failures++; $display("FAIL lanes[%0d] attr_stable got=changed want=stable", i);
            end
            if (e.chk_wd) begin
                checks++;
                if (ob_wdata !== e.wd) begin
                    failures++; $display("FAIL lanes[%0d] bus_wdata got=%h want=%h", i, ob_wdata, e.wd);
                end
            end
            if (e.chk_rd) begin
                checks++;
                if (ob_rdata !== e.rd) begin
                    failures++; $display("FAIL lanes[%0d] rdata got=%h want=%h", i, ob_rdata, e.rd);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  ws[3];
        logic [31:0] as[3];
        int t0;
        ws = '{2'b10, 2'b01, 2'b11};
        as = '{32'h6, 32'h1, 32'h0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 t0 = txn_cnt;
            load_mem = 1'b1; mem_width = ws[k]; addr = as[k]; mem_sign_extend = 1'b0;
            #1;
            checks++;
            if (misaligned !== 1'b1 || stall !== 1'b0 || rdata !== 32'h0) begin
                failures++;
                $display("FAIL misaligned[%0d] got mis=%b stall=%b rd=%h want 1 0 0",
                         k, misaligned, stall, rdata);
            end
            repeat (3) @(negedge clk);
            #1;
            checks++;
            if (txn_cnt != t0 || bus_req !== 1'b0) begin
                failures++;
                $display("FAIL misaligned_nobus[%0d] got txns=%0d req=%b want 0 0", k, txn_cnt - t0, bus_req);
            end
            load_mem = 1'b0;
        end
        @(negedge clk);
        load_mem = 1'b1; mem_width = 2'b00; addr = 32'h3;
        #1;
        checks++;
        if (misaligned !== 1'b0) begin
            failures++; $display("FAIL aligned_byte misaligned got=%b want=0", misaligned);
        end
        load_mem = 1'b0;
    endtask

    task automatic test_held_and_stray();
        int t0;
        logic [31:0] held;
        #1 t0 = txn_cnt;
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h0, 32'h55AA_55AA, 2});
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'h55AA_55AA, 0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        held = exp_q[0].rd;
        void'(exp_q.pop_front());
        checks++;
        if (txn_cnt - t0 != 1) begin
            failures++; $display("FAIL held_access txns got=%0d want=1", txn_cnt - t0);
        end
        checks++;
        if (ob_rdata !== held) begin
            failures++; $display("FAIL held_access rdata got=%h want=%h", ob_rdata, held);
        end
        t0 = txn_cnt;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
        repeat (3) @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++;
        if (txn_cnt != t0 || bus_req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack got txns=%0d req=%b stall=%b want 0 0 0", txn_cnt - t0, bus_req, stall);
        end
        checks++;
        if (rdata !== held) begin
            failures++; $display("FAIL stray_ack rdata_hold got=%h want=%h", rdata, held);
        end
    endtask

    task automatic test_both_high();
        run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b0);
        checks++;
        if (ob_to || ob_we !== 1'b1 || ob_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL both_high store got to=%b we=%b wd=%h want 0 1 12345678", ob_to, ob_we, ob_wdata);
        end
        checks++;
        if (ob_rdata !== 32'h0) begin
            failures++; $display("FAIL both_high rdata got=%h want=0", ob_rdata);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        load_mem = 1'b1; mem_write = 1'b0; mem_width = 2'b10; addr = 32'h30; bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            failures++; $display("FAIL rst_busy_pre bus_req got=%b want=1", bus_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || bus_addr !== 32'h0 || bus_be !== 4'h0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_busy got req=%b addr=%h be=%h rd=%h want zeros", bus_req, bus_addr, bus_be, rdata);
        end
        @(negedge clk);
        load_mem = 1'b0;
        rst_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_AAAA;
        repeat (2) @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || rdata !== 32'h0) begin
            failures++; $display("FAIL rst_no_resume got req=%b rd=%h want 0 0", bus_req, rdata);
        end
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 32'h0F0F_0F0F, 0, 1'b0);
        checks++;
        if (ob_to || ob_cnt != 2 || ob_addr !== 32'h44 || ob_rdata !== 32'h0F0F_0F0F) begin
            failures++;
            $display("FAIL rst_recover got to=%b stall=%0d addr=%h rd=%h want 0 2 44 0f0f0f0f",
                     ob_to, ob_cnt, ob_addr, ob_rdata);
        end
    endtask

    initial begin
        checks = 0; failures = 0; txn_cnt = 0;
        test_reset();
        test_lanes();
        test_misaligned();
        test_held_and_stray();
        test_both_high();
        test_reset_mid_busy();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
